// File: rtl/verifier_line_eval_pkg.sv
// verifier_line_eval_pkg: field definitions, FSM states and modular helpers
// shared by the line evaluator and its Horner step.
package verifier_line_eval_pkg;

    localparam int F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_Q = 61'h1FFF_FFFF_FFFF_FFFF;

    typedef logic [F_NBITS-1:0] fe_t;

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, EVAL, DONE} state_t;

    function automatic fe_t fadd(input fe_t a, input fe_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    // F_Q is a Mersenne prime, so reduction is two folds of the high half.
    function automatic fe_t fred(input logic [2*F_NBITS-1:0] x);
        logic [F_NBITS:0] r;
        r = {1'b0, x[F_NBITS-1:0]} + {1'b0, x[2*F_NBITS-1:F_NBITS]};
        r = {1'b0, r[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, r[F_NBITS]};
        if (r >= {1'b0, F_Q}) r = r - {1'b0, F_Q};
        return r[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/verifier_line_eval_horner.sv
// verifier_horner_step: result = acc*tau + c mod F_Q; two multiplier stages
// plus one add stage, so done pulses three cycles after en.
module verifier_horner_step
    import verifier_line_eval_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  fe_t  acc,
    input  fe_t  tau,
    input  fe_t  c,
    output fe_t  result,
    output logic done
);

    logic [2*F_NBITS-1:0] prod;
    fe_t red, c0, c1;
    logic v0, v1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prod   <= '0;
            red    <= '0;
            c0     <= '0;
            c1     <= '0;
            v0     <= 1'b0;
            v1     <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            prod   <= {{F_NBITS{1'b0}}, acc} * {{F_NBITS{1'b0}}, tau};
            c0     <= c;
            v0     <= en;
            red    <= fred(prod);
            c1     <= c0;
            v1     <= v0;
            result <= fadd(red, c1);
            done   <= v1;
        end
    end

endmodule

// File: rtl/verifier_line_eval.sv
// verifier_line_eval: checks H(0), H(1) of the prover's line polynomial and
// evaluates H(tau) by Horner's rule. VERIFIER_LINE_EVAL_EARLY_ABORT_EN skips EVAL on a failed check.
module verifier_line_eval
    import verifier_line_eval_pkg::*;
#(
    parameter int ndegree = 3
) (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  fe_t  tau,
    input  fe_t  exp_h0,
    input  fe_t  exp_h1,
    input  fe_t  coeff_in,
    input  logic coeff_valid,
    output logic coeff_ready,
    output fe_t  h_tau,
    output logic check_ok,
    output logic ready,
    output logic ready_pulse
);

    localparam int KW = $clog2(ndegree + 1);

    state_t state;
    fe_t tau_q, h0_q, h1_q, sum, acc;
    fe_t coef [ndegree+1];
    logic [KW-1:0] idx, k, k_prev;
    logic ready_dly, ok, abort, step_en, step_done;
    fe_t step_acc, step_c, step_result;

    assign ok = (coef[0] == h0_q) && (sum == h1_q);
`ifdef VERIFIER_LINE_EVAL_EARLY_ABORT_EN
    assign abort = ~ok;
`else
    assign abort = 1'b0;
`endif
    assign k_prev      = k - 1'b1;
    assign ready_pulse = ready & ~ready_dly;

    // The first step issues from CHECK and each later one on the previous done,
    // so every Horner step costs exactly the multiplier-plus-add latency.
    assign step_en  = (state == CHECK && !abort) || (state == EVAL && step_done && k != '0);
    assign step_acc = (state == CHECK) ? coef[ndegree] : step_result;
    assign step_c   = (state == CHECK) ? coef[ndegree-1] : coef[k_prev];

    verifier_horner_step u_step (
        .clk    (clk),
        .rstb   (rstb),
        .en     (step_en),
        .acc    (step_acc),
        .tau    (tau_q),
        .c      (step_c),
        .result (step_result),
        .done   (step_done)
    );

    always_ff @(posedge clk) begin
        if (state == LOAD && coeff_valid) coef[idx] <= coeff_in;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            coeff_ready <= 1'b0;
            h_tau       <= '0;
            check_ok    <= 1'b0;
            ready       <= 1'b1;
            ready_dly   <= 1'b1;
            tau_q       <= '0;
            h0_q        <= '0;
            h1_q        <= '0;
            sum         <= '0;
            acc         <= '0;
            idx         <= '0;
            k           <= '0;
        end else begin
            ready_dly <= ready;
            case (state)
                IDLE: if (en) begin
                    tau_q       <= tau;
                    h0_q        <= exp_h0;
                    h1_q        <= exp_h1;
                    ready       <= 1'b0;
                    idx         <= '0;
                    sum         <= '0;
                    coeff_ready <= 1'b1;
                    state       <= LOAD;
                end
                LOAD: if (coeff_valid) begin
                    sum <= fadd(sum, coeff_in);
                    idx <= idx + 1'b1;
                    if (idx == KW'(ndegree)) begin
                        coeff_ready <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    check_ok <= ok;
                    acc      <= abort ? '0 : coef[ndegree];
                    k        <= KW'(ndegree - 1);
                    state    <= abort ? DONE : EVAL;
                end
                EVAL: if (step_done) begin
                    acc <= step_result;
                    if (k == '0) state <= DONE;
                    else k <= k_prev;
                end
                DONE: begin
                    h_tau <= acc;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
